// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised 2-read/1-write register file.
// The optional parity feature is enabled by defining RF_PARITY_EN.
`timescale 1ns/1ps
package rf_pkg;
    localparam int RF_DATA_W = 4;
    localparam int RF_ADDR_W = 3;

    typedef enum logic {IDLE, CLEAR} rf_state_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, write-to-read bypass, output register.
// With RF_PARITY_EN the stored parity bit is checked and reported on rd_err.
`timescale 1ns/1ps
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int ENT_W  = DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hold,
    input  logic [DEPTH-1:0][ENT_W-1:0]        mem,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               byp_en,
    input  logic [ADDR_W-1:0]                  byp_addr,
    input  logic [DATA_W-1:0]                  byp_val,
`ifdef RF_PARITY_EN
    output logic                               rd_err,
`endif
    output logic [DATA_W-1:0]                  rd_val
);
    logic [ENT_W-1:0] ent;
    logic             hit;

    always_comb begin
        ent = '0;
        if (32'(rd_addr) < 32'(DEPTH))
            ent = mem[rd_addr];
        hit = byp_en && (byp_addr == rd_addr);
    end

    always_ff @(posedge clk) begin
        if (rst || hold) begin
            rd_val <= '0;
`ifdef RF_PARITY_EN
            rd_err <= 1'b0;
`endif
        end else if (hit) begin
            rd_val <= byp_val;
`ifdef RF_PARITY_EN
            rd_err <= 1'b0;
`endif
        end else begin
            rd_val <= ent[DATA_W-1:0];
`ifdef RF_PARITY_EN
            rd_err <= ent[ENT_W-1] ^ (^ent[DATA_W-1:0]);
`endif
        end
    end
endmodule

// File: rtl/rf_param_2r1w.sv
// Register file top: storage, write decode, sequential clear engine, two read ports.
// Define RF_PARITY_EN to add a per-entry parity bit and rdErrA/rdErrB outputs.
`timescale 1ns/1ps
module rf_param_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrVal,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0] rdValA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdValB,
`ifdef RF_PARITY_EN
    output logic              rdErrA,
    output logic              rdErrB,
`endif
    input  logic              clrReq,
    output logic              busy
);
`ifdef RF_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int ENT_W = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e                   state;
    logic [ADDR_W-1:0]           clr_idx;
    logic [DEPTH-1:0][ENT_W-1:0] mem;
    logic [ENT_W-1:0]            wr_ent;
    logic                        wr_commit;

    // A write only lands when idle, not displaced by a clear request, and in range;
    // the bypass keys off the same condition so reads always match what is stored.
    always_comb begin
        wr_commit = (state == IDLE) && !clrReq && wrEn && (32'(wrAddr) < 32'(DEPTH));
`ifdef RF_PARITY_EN
        wr_ent = {even_par(64'(wrVal)), wrVal};
`else
        wr_ent = wrVal;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clrReq) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
            if (wr_commit)
                mem[wrAddr] <= wr_ent;
        end
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ENT_W(ENT_W)) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .hold     (state == CLEAR),
        .mem      (mem),
        .rd_addr  (rdAddrA),
        .byp_en   (wr_commit),
        .byp_addr (wrAddr),
        .byp_val  (wrVal),
`ifdef RF_PARITY_EN
        .rd_err   (rdErrA),
`endif
        .rd_val   (rdValA)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ENT_W(ENT_W)) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .hold     (state == CLEAR),
        .mem      (mem),
        .rd_addr  (rdAddrB),
        .byp_en   (wr_commit),
        .byp_addr (wrAddr),
        .byp_val  (wrVal),
`ifdef RF_PARITY_EN
        .rd_err   (rdErrB),
`endif
        .rd_val   (rdValB)
    );
endmodule

// File: tb/tb_rf_param_2r1w.sv
// Bench for rf_param_2r1w: directed vector table, clear/reset sequences, random traffic vs. a model.
`timescale 1ns/1ps
module tb_rf_param_2r1w;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrEn = 1'b0;
    logic [2:0] wrAddr = '0;
    logic [3:0] wrVal = '0;
    logic [2:0] rdAddrA = '0;
    logic [2:0] rdAddrB = '0;
    logic [3:0] rdValA, rdValB;
    logic       clrReq = 1'b0;
    logic       busy;
`ifdef RF_PARITY_EN
    logic       rdErrA, rdErrB;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: entry contents and how many clear cycles remain.
    int         m_mem [8];
    int         m_left = 0;
    logic [3:0] m_a = '0, m_b = '0;
    logic       m_busy = 1'b0;

    always #5 clk = ~clk;

    rf_param_2r1w dut (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrVal   (wrVal),
        .rdAddrA (rdAddrA),
        .rdValA  (rdValA),
        .rdAddrB (rdAddrB),
        .rdValB  (rdValB),
`ifdef RF_PARITY_EN
        .rdErrA  (rdErrA),
        .rdErrB  (rdErrB),
`endif
        .clrReq  (clrReq),
        .busy    (busy)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural step: the effect of one clock edge with the given inputs.
    task automatic model_step(input logic r, we, input logic [2:0] wa, input logic [3:0] wv,
                              input logic [2:0] aa, ab, input logic cr);
        if (r) begin
            m_left = 8; m_busy = 1'b1; m_a = '0; m_b = '0;
            foreach (m_mem[i]) m_mem[i] = 0;
        end else if (m_left > 0) begin
            m_a = '0; m_b = '0;
            m_left--;
            m_busy = (m_left > 0);
        end else begin
            m_a = (we && !cr && wa == aa) ? wv : 4'(m_mem[aa]);
            m_b = (we && !cr && wa == ab) ? wv : 4'(m_mem[ab]);
            if (cr) begin
                m_left = 8; m_busy = 1'b1;
                foreach (m_mem[i]) m_mem[i] = 0;
            end else if (we) begin
                m_mem[wa] = int'(wv);
            end
        end
    endtask

    task automatic cycle(input logic r, we, input logic [2:0] wa, input logic [3:0] wv,
                         input logic [2:0] aa, ab, input logic cr);
        @(negedge clk);
        rst = r; wrEn = we; wrAddr = wa; wrVal = wv; rdAddrA = aa; rdAddrB = ab; clrReq = cr;
        model_step(r, we, wa, wv, aa, ab, cr);
        @(posedge clk);
        #1;
        chk("model_rdValA", 8'(rdValA), 8'(m_a));
        chk("model_rdValB", 8'(rdValB), 8'(m_b));
        chk("model_busy", 8'(busy), 8'(m_busy));
`ifdef RF_PARITY_EN
        chk("model_rdErrA", 8'(rdErrA), 8'h0);
        chk("model_rdErrB", 8'(rdErrB), 8'h0);
`endif
    endtask

    typedef struct {
        logic       r, we;
        logic [2:0] wa;
        logic [3:0] wv;
        logic [2:0] aa, ab;
        logic       cr;
        logic [3:0] xa, xb;
        logic       xbusy;
    } vec_t;

    function automatic vec_t mk(input logic r, we, input logic [2:0] wa, input logic [3:0] wv,
                                input logic [2:0] aa, ab, input logic [3:0] xa, xb,
                                input logic xbusy);
        vec_t v;
        v.r = r; v.we = we; v.wa = wa; v.wv = wv; v.aa = aa; v.ab = ab; v.cr = 1'b0;
        v.xa = xa; v.xb = xb; v.xbusy = xbusy;
        return v;
    endfunction

    vec_t vt [24];

    initial begin
        int cnt;

        // Reset, busy window, zeroed read-back, write/read, bypass, edge addresses.
        vt[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) vt[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, (i < 8));
        for (int i = 0; i < 8; i++)  vt[9+i] = mk(0, 0, 0, 0, 3'(i), 3'(7-i), 0, 0, 0);
        vt[17] = mk(0, 1, 3, 4'hA, 0, 0, 4'h0, 4'h0, 0);
        vt[18] = mk(0, 0, 0, 0,    3, 3, 4'hA, 4'hA, 0);
        vt[19] = mk(0, 1, 5, 4'h2, 0, 0, 4'h0, 4'h0, 0);
        vt[20] = mk(0, 1, 5, 4'h9, 5, 3, 4'h9, 4'hA, 0);
        vt[21] = mk(0, 0, 0, 0,    5, 5, 4'h9, 4'h9, 0);
        vt[22] = mk(0, 1, 7, 4'h5, 0, 7, 4'h0, 4'h5, 0);
        vt[23] = mk(0, 1, 0, 4'h3, 0, 7, 4'h3, 4'h5, 0);

        for (int i = 0; i < 24; i++) begin
            cycle(vt[i].r, vt[i].we, vt[i].wa, vt[i].wv, vt[i].aa, vt[i].ab, vt[i].cr);
            chk($sformatf("vec%0d_rdValA", i), 8'(rdValA), 8'(vt[i].xa));
            chk($sformatf("vec%0d_rdValB", i), 8'(rdValB), 8'(vt[i].xb));
            chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(vt[i].xbusy));
        end

        // Clear request: fill with 0xF, clear, a write during busy must be dropped.
        for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), 4'hF, 0, 0, 0);
        cycle(0, 0, 0, 0, 2, 2, 1);
        cnt = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            cycle(0, (k == 0), 2, 4'h7, 2, 2, 0);
            cnt++;
        end
        chk("clr_busy_cycles", 8'(cnt), 8'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 3'(i), 3'(7-i), 0);
            chk("clr_readback_A", 8'(rdValA), 8'h0);
            chk("clr_readback_B", 8'(rdValB), 8'h0);
        end

        // Reset in the middle of a clear restarts the full sweep.
        for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), 4'(i + 1), 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            cnt++;
        end
        chk("rst_mid_clear_busy_cycles", 8'(cnt), 8'd8);
        cycle(0, 0, 0, 0, 6, 7, 0);
        chk("rst_mid_clear_readback", 8'({rdValA, rdValB}), 8'h00);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), 4'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 59) == 0));
        end

`ifdef RF_PARITY_EN
        // Corrupt one stored data bit and confirm the parity check sees it.
        for (int k = 0; k < 20 && busy; k++) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 6, 4'h4, 0, 0, 0);
        cycle(0, 1, 1, 4'h3, 0, 0, 0);
        @(negedge clk);
        dut.mem[6][0] = ~dut.mem[6][0];
        rst = 0; wrEn = 0; clrReq = 0; rdAddrA = 6; rdAddrB = 1;
        @(posedge clk);
        #1;
        chk("parity_err_corrupt", 8'(rdErrA), 8'h1);
        chk("parity_err_clean_B", 8'(rdErrB), 8'h0);
        @(negedge clk);
        rdAddrA = 1;
        @(posedge clk);
        #1;
        chk("parity_err_clean_A", 8'(rdErrA), 8'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end
endmodule
